// File: rtl/seg_code_pkg.sv
// Shared code set for the 8-digit seven-segment path: glyph codes, canned words,
// converter FSM encoding and the double-dabble digit correction.
package seg_code_pkg;

  localparam logic [3:0] SEG_DASH  = 4'ha;
  localparam logic [3:0] SEG_BLANK = 4'hb;
  localparam logic [3:0] SEG_E     = 4'hc;
  localparam logic [3:0] SEG_R     = 4'hd;

  localparam logic [31:0] ERR_WORD   = 32'hBBBB_BCDD;
  localparam logic [31:0] BLANK_WORD = 32'hBBBB_BBBB;

  // Largest magnitudes that fit in eight digits (seven when one is spent on the dash).
  localparam logic [31:0] MAX_POS_MAG = 32'd99_999_999;
  localparam logic [31:0] MAX_NEG_MAG = 32'd9_999_999;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_FMT   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: correct every BCD digit, then shift
// the {bcd, mag} pair left by one bit.
module bcd_dabble_step
  import seg_code_pkg::*;
(
  input  logic [31:0] bcd_in,
  input  logic [31:0] mag_in,
  output logic [31:0] bcd_out,
  output logic [31:0] mag_out
);

  logic [31:0] adj_s;

  // Per-digit add-3 correction ahead of the shift.
  always_comb begin
    adj_s = 32'h0;
    for (int i = 0; i < 8; i++) begin
      adj_s[i*4 +: 4] = add3(bcd_in[i*4 +: 4]);
    end
  end

  // The top bit of the accumulator is dropped; overflow is flagged before shifting starts.
  assign bcd_out = {adj_s[30:0], mag_in[31]};
  assign mag_out = {mag_in[30:0], 1'b0};

endmodule

// File: rtl/bin2bcd8d.sv
// Sequential 32-bit binary to 8-digit display-code converter. The result word is held
// between conversions so the digit scanner never sees partial values.
module bin2bcd8d
  import seg_code_pkg::*;
#(
  parameter bit P_SIGNED = 1'b0,
  parameter bit P_BLANK  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  input  logic [31:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_bcd8d
);

  logic [2:0]  state_r;
  logic [31:0] in_r;
  logic [31:0] mag_r;
  logic [31:0] bcd_r;
  logic [4:0]  cnt_r;
  logic        neg_r;
  logic        ovf_r;
  logic [31:0] word_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] bcd8d_r;

  logic        neg_s;
  logic [31:0] mag_load_s;
  logic        ovf_s;
  logic [31:0] step_bcd_s;
  logic [31:0] step_mag_s;
  logic [2:0]  msd_s;
  logic [31:0] body_s;
  logic [31:0] fmt_s;

  // Sign and overflow decision on the captured input; 0x8000_0000 negates to 2^31.
  always_comb begin
    neg_s      = P_SIGNED && in_r[31];
    mag_load_s = neg_s ? (~in_r + 32'd1) : in_r;
    ovf_s      = mag_load_s > (neg_s ? MAX_NEG_MAG : MAX_POS_MAG);
  end

  bcd_dabble_step u_step (
    .bcd_in  (bcd_r),
    .mag_in  (mag_r),
    .bcd_out (step_bcd_s),
    .mag_out (step_mag_s)
  );

  // Leading-zero blanking and dash placement left of the most significant shown digit.
  always_comb begin
    msd_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      msd_s = (bcd_r[i*4 +: 4] != 4'd0) ? 3'(i) : msd_s;
    end
    body_s = bcd_r;
    for (int i = 1; i < 8; i++) begin
      body_s[i*4 +: 4] = (P_BLANK && (i > int'(msd_s))) ? SEG_BLANK : bcd_r[i*4 +: 4];
    end
    fmt_s = body_s;
    if (ovf_r) begin
      fmt_s = ERR_WORD;
    end else if (neg_r && P_BLANK) begin
      for (int i = 1; i < 8; i++) begin
        fmt_s[i*4 +: 4] = (i == int'(msd_s) + 1) ? SEG_DASH : body_s[i*4 +: 4];
      end
    end else if (neg_r) begin
      fmt_s[31:28] = SEG_DASH;
    end else begin
      fmt_s = body_s;
    end
  end

  // Conversion FSM; the output word is written only when leaving DONE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
      in_r    <= 32'h0;
      mag_r   <= 32'h0;
      bcd_r   <= 32'h0;
      cnt_r   <= 5'd0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
      word_r  <= BLANK_WORD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd8d_r <= BLANK_WORD;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (done_r) begin
            busy_r <= 1'b0;
          end else if (i_valid && !busy_r) begin
            in_r    <= i_bin;
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            busy_r <= busy_r;
          end
        end
        ST_LOAD: begin
          neg_r   <= neg_s;
          mag_r   <= mag_load_s;
          ovf_r   <= ovf_s;
          bcd_r   <= 32'h0;
          cnt_r   <= 5'd31;
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_r <= step_bcd_s;
          mag_r <= step_mag_s;
          if (cnt_r == 5'd0) begin
            state_r <= ST_FMT;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_FMT: begin
          word_r  <= fmt_s;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          bcd8d_r <= word_r;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = busy_r;
  assign o_done  = done_r;
  assign o_bcd8d = bcd8d_r;

endmodule

// File: tb/tb_bin2bcd8d.sv
// Bench for bin2bcd8d: three parameterisations checked every cycle against an
// arithmetic reference model, plus directed vectors with literal expected words.
module tb_bin2bcd8d;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid [3];
  logic [31:0] bin   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [31:0] bcd   [3];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt [3];

  bit          m_busy [3];
  int          m_cnt  [3];
  bit          m_done [3];
  logic [31:0] m_word [3];
  logic [31:0] m_pend [3];

  always #5 clk = ~clk;

  bin2bcd8d #(.P_SIGNED(1'b0), .P_BLANK(1'b1)) u_a (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid[0]), .i_bin(bin[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_bcd8d(bcd[0]));
  bin2bcd8d #(.P_SIGNED(1'b1), .P_BLANK(1'b0)) u_b (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid[1]), .i_bin(bin[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_bcd8d(bcd[1]));
  bin2bcd8d #(.P_SIGNED(1'b1), .P_BLANK(1'b1)) u_c (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid[2]), .i_bin(bin[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_bcd8d(bcd[2]));

  function automatic bit sgn_of(input int k);
    return k != 0;
  endfunction

  function automatic bit blk_of(input int k);
    return k != 1;
  endfunction

  // Reference: decimal digits by division, then blanking and sign placement.
  function automatic logic [31:0] fmt_model(input logic [31:0] v, input bit sgn, input bit blk);
    longint mag;
    longint t;
    bit     neg;
    int     nd;
    logic [31:0] w;
    neg = sgn && v[31];
    mag = longint'({32'h0, v});
    if (neg) mag = 64'sd4294967296 - mag;
    if (mag > (neg ? 64'sd9999999 : 64'sd99999999)) return 32'hBBBB_BCDD;
    t  = mag;
    nd = 1;
    w  = 32'h0;
    for (int i = 0; i < 8; i++) begin
      w[i*4 +: 4] = 4'(t % 10);
      if (t % 10 != 0) nd = i + 1;
      t = t / 10;
    end
    if (blk) for (int i = nd; i < 8; i++) w[i*4 +: 4] = 4'hB;
    if (neg) begin
      if (blk) w[nd*4 +: 4] = 4'hA;
      else     w[31:28] = 4'hA;
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: 35 edges from accept to done, busy until the edge after done.
  always @(posedge clk or negedge rstn) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        m_busy[k] = 1'b0; m_cnt[k] = 0; m_done[k] = 1'b0;
        m_word[k] = 32'hBBBB_BBBB; m_pend[k] = 32'h0;
      end else if (!m_busy[k]) begin
        m_done[k] = 1'b0;
        if (valid[k]) begin
          m_busy[k] = 1'b1; m_cnt[k] = 0;
          m_pend[k] = fmt_model(bin[k], sgn_of(k), blk_of(k));
        end
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == 35) begin
          m_word[k] = m_pend[k]; m_done[k] = 1'b1;
        end else if (m_cnt[k] == 36) begin
          m_busy[k] = 1'b0; m_done[k] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("word%0d", k), bcd[k], m_word[k]);
      check($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
      if (!(m_busy[k] && m_cnt[k] == 0))
        check($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
      if (done[k] === 1'b1) done_cnt[k]++;
    end
  end

  task automatic start(input int k, input logic [31:0] v);
    @(negedge clk);
    valid[k] = 1'b1;
    bin[k]   = v;
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int e);
    e = 0;
    while (done[k] !== 1'b1 && e < 60) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic run(input int k, input logic [31:0] v, input logic [31:0] exp);
    int e;
    check($sformatf("model_pin_%h", v), fmt_model(v, sgn_of(k), blk_of(k)), exp);
    start(k, v);
    wait_done(k, e);
    check($sformatf("latency_%h", v), 32'(e), 32'd35);
    check($sformatf("result_%h", v), bcd[k], exp);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e;
    int d0;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0; bin[k] = 32'h0; done_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("reset_word", bcd[0], 32'hBBBB_BBBB);
    check("reset_busy", 32'(busy[0]), 32'd0);

    run(0, 32'd12_345_678, 32'h1234_5678);
    run(0, 32'd42,          32'hBBBB_BB42);
    run(0, 32'd0,           32'hBBBB_BBB0);
    run(0, 32'd99_999_999,  32'h9999_9999);
    run(0, 32'd100_000_000, 32'hBBBB_BCDD);
    run(0, 32'hFFFF_FFFF,   32'hBBBB_BCDD);
    run(1, 32'd42,          32'h0000_0042);
    run(1, 32'hFFFF_FFD6,   32'hA000_0042);
    run(1, 32'd0,           32'h0000_0000);
    run(2, 32'hFFFF_FFD6,   32'hBBBB_BA42);
    run(2, 32'hFF67_6981,   32'hA999_9999);
    run(2, 32'hFF67_6980,   32'hBBBB_BCDD);
    run(2, 32'h8000_0000,   32'hBBBB_BCDD);
    run(2, 32'd9_999_999,   32'hB999_9999);
    run(2, 32'd10_000_000,  32'h1000_0000);

    // Request while busy is dropped.
    d0 = done_cnt[0];
    start(0, 32'd55);
    repeat (5) @(negedge clk);
    valid[0] = 1'b1;
    bin[0]   = 32'd7;
    @(negedge clk);
    valid[0] = 1'b0;
    wait_done(0, e);
    check("busy_drop_result", bcd[0], 32'hBBBB_BB55);
    repeat (45) @(negedge clk);
    check("busy_drop_count", 32'(done_cnt[0] - d0), 32'd1);

    // Reset in the middle of shifting aborts without a done pulse.
    d0 = done_cnt[0];
    start(0, 32'd87_654_321);
    repeat (11) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_word", bcd[0], 32'hBBBB_BBBB);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (45) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
    run(0, 32'd305, 32'hBBBB_B305);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
